// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate controller for a 2048 x 64-bit data-cache array.
// Keeps the tag/valid/dirty state and handles misses through a one-outstanding memory port.
module dcache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 512
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         cpu_req_valid,
  output logic                                         cpu_req_ready,
  input  logic                                         cpu_req_we,
  input  logic [ADDR_W-1:0]                            cpu_req_addr,
  input  logic [63:0]                                  cpu_req_wdata,
  input  logic [7:0]                                   cpu_req_wstrb,
  output logic                                         cpu_resp_valid,
  output logic [63:0]                                  cpu_resp_rdata,
  output logic [$clog2(NUM_LINES*LINE_WORDS)-1:0]      arr_rd_index,
  input  logic [63:0]                                  arr_rd_data,
  output logic                                         arr_wr_en,
  output logic [$clog2(NUM_LINES*LINE_WORDS)-1:0]      arr_wr_index,
  output logic [63:0]                                  arr_wr_data,
  output logic                                         mem_req_valid,
  input  logic                                         mem_req_ready,
  output logic                                         mem_req_we,
  output logic [ADDR_W-1:0]                            mem_req_addr,
  output logic [63:0]                                  mem_req_wdata,
  input  logic                                         mem_resp_valid,
  input  logic [63:0]                                  mem_resp_data
);

  localparam int OFF_W   = 3;
  localparam int BEAT_W  = $clog2(LINE_WORDS);
  localparam int LINE_W  = $clog2(NUM_LINES);
  localparam int IDX_W   = LINE_W + BEAT_W;
  localparam int TAG_LSB = OFF_W + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WB,
    S_RF_REQ,
    S_RF_WAIT
  } state_t;

  state_t                   state, state_nxt;
  logic [BEAT_W-1:0]        beat, beat_nxt;
  logic                     rst_q;

  logic                     req_we;
  logic [ADDR_W-1:OFF_W]    req_addr;
  logic [63:0]              req_wdata;
  logic [7:0]               req_wstrb;

  logic [TAG_W-1:0]         tag_q [NUM_LINES];
  logic [NUM_LINES-1:0]     valid_q;
  logic [NUM_LINES-1:0]     dirty_q;

  logic [LINE_W-1:0]        req_line;
  logic [TAG_W-1:0]         req_tag;
  logic [IDX_W-1:0]         req_widx;
  logic [IDX_W-1:0]         beat_idx;
  logic [TAG_W-1:0]         victim_tag;
  logic                     hit;
  logic [63:0]              merged;
  logic                     accept;
  logic                     set_dirty;
  logic                     fill_done;

  // Byte offset of the core address is a don't-care.
  logic                     unused_addr_bits;
  assign unused_addr_bits = ^cpu_req_addr[OFF_W-1:0];

  assign req_line   = req_addr[TAG_LSB-1:OFF_W+BEAT_W];
  assign req_tag    = req_addr[ADDR_W-1:TAG_LSB];
  assign req_widx   = req_addr[TAG_LSB-1:OFF_W];
  assign beat_idx   = {req_line, beat};
  assign victim_tag = tag_q[req_line];
  assign hit        = valid_q[req_line] && (victim_tag == req_tag);

  always_comb begin
    merged = arr_rd_data;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req_wstrb[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_nxt      = state;
    beat_nxt       = beat;
    accept         = 1'b0;
    set_dirty      = 1'b0;
    fill_done      = 1'b0;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    arr_rd_index   = req_widx;
    arr_wr_en      = 1'b0;
    arr_wr_index   = req_widx;
    arr_wr_data    = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;

    unique case (state)
      S_IDLE: begin
        cpu_req_ready = !rst_q;
        if (cpu_req_valid && !rst_q) begin
          accept    = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          if (req_we) begin
            arr_wr_en   = 1'b1;
            arr_wr_data = merged;
            set_dirty   = 1'b1;
          end else begin
            cpu_resp_rdata = arr_rd_data;
          end
          state_nxt = S_IDLE;
        end else begin
          beat_nxt  = '0;
          state_nxt = (valid_q[req_line] && dirty_q[req_line]) ? S_WB : S_RF_REQ;
        end
      end
      S_WB: begin
        arr_rd_index  = beat_idx;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {victim_tag, req_line, beat, {OFF_W{1'b0}}};
        mem_req_wdata = arr_rd_data;
        if (mem_req_ready) begin
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = S_RF_REQ;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      S_RF_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_line, beat, {OFF_W{1'b0}}};
        if (mem_req_ready) state_nxt = S_RF_WAIT;
      end
      S_RF_WAIT: begin
        if (mem_resp_valid) begin
          arr_wr_en    = 1'b1;
          arr_wr_index = beat_idx;
          arr_wr_data  = mem_resp_data;
          if (beat == LAST_BEAT) begin
            fill_done = 1'b1;
            state_nxt = S_CHECK;
          end else begin
            beat_nxt  = beat + 1'b1;
            state_nxt = S_RF_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Reset squashes every side effect in the same cycle so an in-flight miss is dropped at once.
    if (reset) begin
      accept         = 1'b0;
      set_dirty      = 1'b0;
      fill_done      = 1'b0;
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = '0;
      arr_wr_en      = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      beat    <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      rst_q   <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      state <= state_nxt;
      beat  <= beat_nxt;
      if (set_dirty) dirty_q[req_line] <= 1'b1;
      if (fill_done) begin
        valid_q[req_line] <= 1'b1;
        dirty_q[req_line] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= cpu_req_we;
      req_addr  <= cpu_req_addr[ADDR_W-1:OFF_W];
      req_wdata <= cpu_req_wdata;
      req_wstrb <= cpu_req_wstrb;
    end
    if (fill_done) tag_q[req_line] <= req_tag;
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: transaction-level cache model predicting memory traffic and responses,
// plus a behavioural array and backing memory around the controller.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [63:0] cpu_req_wdata;
  logic [7:0]  cpu_req_wstrb;
  logic        cpu_resp_valid;
  logic [63:0] cpu_resp_rdata;
  logic [10:0] arr_rd_index, arr_wr_index;
  logic [63:0] arr_rd_data, arr_wr_data;
  logic        arr_wr_en;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  dcache_ctrl #(.ADDR_W(32), .LINE_WORDS(4), .NUM_LINES(512)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .arr_rd_index(arr_rd_index), .arr_rd_data(arr_rd_data), .arr_wr_en(arr_wr_en),
    .arr_wr_index(arr_wr_index), .arr_wr_data(arr_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          resp_count = 0;
  logic [63:0] last_rdata = '0;
  int          stall_seen = 0;
  logic        arm_stall = 1'b0;

  mreq_t       exp_mem[$];
  logic [63:0] exp_resp[$];
  mreq_t       mem_log[$];

  logic [63:0] arr [0:2047];
  logic [63:0] mem [0:8191];
  logic [63:0] ref_mem [0:8191];

  logic        m_valid [512];
  logic        m_dirty [512];
  logic [17:0] m_tag   [512];
  logic [63:0] m_data  [512][4];

  assign arr_rd_data = arr[arr_rd_index];
  always @(posedge clk) if (arr_wr_en) arr[arr_wr_index] <= arr_wr_data;

  function automatic logic [63:0] init_word(input int unsigned idx);
    if (idx >= 32'h200 && idx < 32'h204) return 64'hA0 + 64'(idx - 32'h200);
    if (idx >= 32'hA00 && idx < 32'hA04) return 64'hB0 + 64'(idx - 32'hA00);
    return 64'hD000_0000_0000_0000 | 64'(idx);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_mem.delete();
    exp_resp.delete();
  endtask

  // Cache semantics at transaction level: which memory beats a request causes and what it returns.
  task automatic model_req(input logic we, input logic [31:0] a, input logic [63:0] wd,
                           input logic [7:0] ws);
    logic [8:0]  line;
    logic [17:0] tag;
    logic [1:0]  b;
    mreq_t       e;
    line = a[13:5];
    tag  = a[31:14];
    b    = a[4:3];
    if (!(m_valid[line] && m_tag[line] == tag)) begin
      if (m_valid[line] && m_dirty[line]) begin
        for (int k = 0; k < 4; k++) begin
          e.we    = 1'b1;
          e.addr  = {m_tag[line], line, 2'(k), 3'b000};
          e.wdata = m_data[line][k];
          exp_mem.push_back(e);
          ref_mem[e.addr[15:3]] = e.wdata;
        end
      end
      for (int k = 0; k < 4; k++) begin
        e.we    = 1'b0;
        e.addr  = {tag, line, 2'(k), 3'b000};
        e.wdata = '0;
        exp_mem.push_back(e);
        m_data[line][k] = ref_mem[e.addr[15:3]];
      end
      m_tag[line]   = tag;
      m_valid[line] = 1'b1;
      m_dirty[line] = 1'b0;
    end
    if (we) begin
      for (int i = 0; i < 8; i++) if (ws[i]) m_data[line][b][8*i +: 8] = wd[8*i +: 8];
      m_dirty[line] = 1'b1;
      exp_resp.push_back('0);
    end else begin
      exp_resp.push_back(m_data[line][b]);
    end
  endtask

  // Backing memory: one outstanding read, data returned the cycle after acceptance.
  initial begin : responder
    logic        pend;
    logic [63:0] pend_data;
    int          stall;
    logic        stall_done;
    pend = 1'b0; pend_data = '0; stall = 0; stall_done = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      if (pend) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = pend_data;
        pend = 1'b0;
      end
      if (stall > 0) stall--;
      mem_req_ready = (stall == 0);
      #1;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (arm_stall && !stall_done && mem_req_valid && mem_req_we && mem_req_addr[4:3] == 2'd2) begin
          stall = 5;
          stall_done = 1'b1;
          mem_req_ready = 1'b0;
        end
        if (mem_req_valid && !mem_req_ready && mem_req_addr == 32'h1010) stall_seen++;
        if (mem_req_valid && mem_req_ready) begin
          if (mem_req_we) mem[mem_req_addr[15:3]] = mem_req_wdata;
          else begin
            pend = 1'b1;
            pend_data = mem[mem_req_addr[15:3]];
          end
        end
      end
    end
  end

  logic        prev_rst = 1'b1, prev_mv = 1'b0, prev_mr = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [63:0] prev_wd = '0;

  initial begin : compare
    mreq_t e, got;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        chk("rst_req_ready", 64'(cpu_req_ready), 0);
        chk("rst_resp_valid", 64'(cpu_resp_valid), 0);
        chk("rst_resp_rdata", cpu_resp_rdata, 0);
        chk("rst_arr_wr_en", 64'(arr_wr_en), 0);
        chk("rst_mem_valid", 64'(mem_req_valid), 0);
        chk("rst_mem_we", 64'(mem_req_we), 0);
      end else begin
        if (prev_rst) chk("post_rst_req_ready", 64'(cpu_req_ready), 0);
        if (prev_mv && !prev_mr && !prev_rst) begin
          chk("stall_valid", 64'(mem_req_valid), 1);
          chk("stall_we", 64'(mem_req_we), 64'(prev_we));
          chk("stall_addr", 64'(mem_req_addr), 64'(prev_addr));
          chk("stall_wdata", mem_req_wdata, prev_wd);
        end
        if (mem_req_valid && mem_req_ready) begin
          got.we = mem_req_we; got.addr = mem_req_addr; got.wdata = mem_req_wdata;
          mem_log.push_back(got);
          if (exp_mem.size() == 0) chk("mem_unexpected", 64'(mem_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_mem.pop_front();
            chk("mem_we", 64'(mem_req_we), 64'(e.we));
            chk("mem_addr", 64'(mem_req_addr), 64'(e.addr));
            if (e.we) chk("mem_wdata", mem_req_wdata, e.wdata);
          end
        end
        if (cpu_resp_valid) begin
          resp_count++;
          last_rdata = cpu_resp_rdata;
          if (exp_resp.size() == 0) chk("resp_unexpected", 64'(cpu_resp_valid), 0);
          else chk("resp_rdata", cpu_resp_rdata, exp_resp.pop_front());
        end
      end
      prev_rst  = reset;
      prev_mv   = mem_req_valid;
      prev_mr   = mem_req_ready;
      prev_we   = mem_req_we;
      prev_addr = mem_req_addr;
      prev_wd   = mem_req_wdata;
    end
  end

  task automatic issue(input logic we, input logic [31:0] a, input logic [63:0] wd,
                       input logic [7:0] ws);
    int n;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_req_ready) chk("req_ready_timeout", 0, 1);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = wd;
    cpu_req_wstrb = ws;
    model_req(we, a, wd, ws);
    @(negedge clk);
    cpu_req_valid = 1'b0;
  endtask

  // lat counts cycles from acceptance to the response pulse.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, output int lat);
    int base;
    base = resp_count;
    issue(we, a, wd, ws);
    #3;
    lat = 1;
    while (resp_count == base && lat < 400) begin
      @(negedge clk);
      #3;
      lat++;
    end
    if (resp_count == base) chk("resp_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          lat, base, n;
    logic [63:0] wb_data [4];
    wb_data[0] = 64'hA0; wb_data[1] = 64'h0000_0000_FFFF_FFFF;
    wb_data[2] = 64'hA2; wb_data[3] = 64'hA3;
    reset = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0;
    cpu_req_wdata = '0;   cpu_req_wstrb = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    base = mem_log.size();
    do_req(1'b0, 32'h0000_1008, '0, '0, lat);
    chk("cold_beats", 64'(mem_log.size() - base), 4);
    for (int k = 0; k < 4; k++) chk("cold_rd_addr", 64'(mem_log[base+k].addr), 64'(32'h1000 + 8*k));
    chk("cold_rdata", last_rdata, 64'hA1);
    chk("cold_model_valid", 64'(m_valid[9'h080]), 1);

    base = mem_log.size();
    do_req(1'b0, 32'h0000_1008, '0, '0, lat);
    chk("hit_latency", 64'(lat), 1);
    chk("hit_rdata", last_rdata, 64'hA1);
    chk("hit_no_mem", 64'(mem_log.size() - base), 0);
    @(negedge clk);
    chk("hit_next_ready", 64'(cpu_req_ready), 1);

    do_req(1'b1, 32'h0000_1008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, lat);
    chk("store_latency", 64'(lat), 1);
    chk("store_rdata", last_rdata, 64'h0);
    @(posedge clk);
    #1;
    chk("store_array_word", arr[11'h201], 64'h0000_0000_FFFF_FFFF);
    chk("store_model_dirty", 64'(m_dirty[9'h080]), 1);

    arm_stall = 1'b1;
    base = mem_log.size();
    do_req(1'b0, 32'h0000_5008, '0, '0, lat);
    chk("evict_beats", 64'(mem_log.size() - base), 8);
    for (int k = 0; k < 4; k++) begin
      chk("evict_wb_we", 64'(mem_log[base+k].we), 1);
      chk("evict_wb_addr", 64'(mem_log[base+k].addr), 64'(32'h1000 + 8*k));
      chk("evict_wb_data", mem_log[base+k].wdata, wb_data[k]);
      chk("evict_rf_addr", 64'(mem_log[base+4+k].addr), 64'(32'h5000 + 8*k));
    end
    chk("stall_cycles", 64'(stall_seen), 5);
    chk("evict_rdata", last_rdata, 64'hB1);
    chk("evict_mem_word", mem[13'h201], 64'h0000_0000_FFFF_FFFF);
    chk("evict_model_dirty", 64'(m_dirty[9'h080]), 0);

    base = mem_log.size();
    do_req(1'b0, 32'h0000_1008, '0, '0, lat);
    chk("clean_miss_beats", 64'(mem_log.size() - base), 4);
    chk("clean_miss_rdata", last_rdata, 64'h0000_0000_FFFF_FFFF);

    base = mem_log.size();
    issue(1'b0, 32'h0000_5010, '0, '0);
    n = 0;
    while (mem_log.size() < base + 2 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk("abort_reach_beat1", 64'(mem_log.size() >= base + 2), 1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("abort_beats", 64'(mem_log.size() - base), 2);

    base = mem_log.size();
    do_req(1'b0, 32'h0000_5010, '0, '0, lat);
    chk("after_abort_beats", 64'(mem_log.size() - base), 4);
    chk("after_abort_rdata", last_rdata, 64'hB2);

    repeat (3) @(negedge clk);
    chk("exp_mem_drained", 64'(exp_mem.size()), 0);
    chk("exp_resp_drained", 64'(exp_resp.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
